// File: rtl/ahb_bus.sv
// Single-outstanding AHB-Lite read master: each READ request fetches one
// halfword from a wrapping address sequence and reports the slave response.
module ahb_bus #(
   parameter logic [31:0] ADDR_START = 32'h0000_0000,
   parameter logic [31:0] ADDR_LAST  = 32'h0000_00FE,
   parameter logic [31:0] ADDR_INCR  = 32'd2
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        READ,
   output logic [15:0] DATAOUT,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic [31:0] HWDATA,
   input  logic [15:0] HRDATA,
   input  logic        HREADY,
   input  logic [1:0]  HRESP,
   output logic [1:0]  RESP_err,
   output logic        AHB_BUSY,
   output logic        VALID,
   output logic [1:0]  fsm_state
);

   // Handshake: READ is a level request sampled only in IDLE; a slave phase
   // completes on any rising edge where HREADY=1; VALID strobes one cycle
   // when DATAOUT has been loaded from an OKAY completion.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   state_t      state;
   logic [31:0] next_addr;

   // HADDR doubles as the address register: it only moves on an OKAY
   // completion, so it is stable through the address phase by construction.
   always_comb begin
      next_addr = HADDR + ADDR_INCR;
      if (HADDR == ADDR_LAST) begin
         next_addr = ADDR_START;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESETn) begin
         state    <= IDLE;
         HADDR    <= ADDR_START;
         HTRANS   <= TRANS_IDLE;
         DATAOUT  <= 16'h0000;
         RESP_err <= 2'b00;
         AHB_BUSY <= 1'b0;
         VALID    <= 1'b0;
      end else begin
         VALID <= 1'b0;
         case (state)
            IDLE: begin
               if (READ) begin
                  state    <= ADDR;
                  HTRANS   <= TRANS_NONSEQ;
                  AHB_BUSY <= 1'b1;
               end
            end
            ADDR: begin
               if (HREADY) begin
                  state  <= DATA;
                  HTRANS <= TRANS_IDLE;
               end
            end
            DATA: begin
               if (HREADY) begin
                  state    <= IDLE;
                  AHB_BUSY <= 1'b0;
                  RESP_err <= HRESP;
                  if (HRESP == 2'b00) begin
                     DATAOUT <= HRDATA;
                     VALID   <= 1'b1;
                     HADDR   <= next_addr;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               HTRANS   <= TRANS_IDLE;
               AHB_BUSY <= 1'b0;
            end
         endcase
      end
   end

   assign fsm_state = state;

   // Fixed attributes of a privileged, single-beat halfword data read.
   assign HWRITE = 1'b0;
   assign HSIZE  = 3'b001;
   assign HBURST = 3'b000;
   assign HPROT  = 4'b0011;
   assign HWDATA = 32'h0000_0000;

endmodule

// File: tb/tb_ahb_bus.sv
// Directed bench for ahb_bus: reset, zero-wait reads, wait states, error
// retry, address wrap with a short window, and reset during a data phase.
module tb_ahb_bus;

   logic        HCLK;
   logic        HRESETn;
   logic        READ;
   logic [15:0] DATAOUT;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic [15:0] HRDATA;
   logic        HREADY;
   logic [1:0]  HRESP;
   logic [1:0]  RESP_err;
   logic        AHB_BUSY;
   logic        VALID;
   logic [1:0]  fsm_state;

   int checks   = 0;
   int failures = 0;

   ahb_bus #(
      .ADDR_START(32'h0000_0000),
      .ADDR_LAST (32'h0000_0004),
      .ADDR_INCR (32'd2)
   ) dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .READ     (READ),
      .DATAOUT  (DATAOUT),
      .HADDR    (HADDR),
      .HTRANS   (HTRANS),
      .HWRITE   (HWRITE),
      .HSIZE    (HSIZE),
      .HBURST   (HBURST),
      .HPROT    (HPROT),
      .HWDATA   (HWDATA),
      .HRDATA   (HRDATA),
      .HREADY   (HREADY),
      .HRESP    (HRESP),
      .RESP_err (RESP_err),
      .AHB_BUSY (AHB_BUSY),
      .VALID    (VALID),
      .fsm_state(fsm_state)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; outputs are then sampled and inputs changed 1ns later.
   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic check_bus(input string tag, input logic [1:0] trans, input logic [31:0] addr,
                            input logic busy, input logic valid);
      check({tag, "_htrans"}, {30'd0, HTRANS}, {30'd0, trans});
      check({tag, "_haddr"}, HADDR, addr);
      check({tag, "_busy"}, {31'd0, AHB_BUSY}, {31'd0, busy});
      check({tag, "_valid"}, {31'd0, VALID}, {31'd0, valid});
   endtask

   task automatic check_consts(input string tag);
      check({tag, "_hwrite"}, {31'd0, HWRITE}, 32'd0);
      check({tag, "_hsize"}, {29'd0, HSIZE}, 32'd1);
      check({tag, "_hburst"}, {29'd0, HBURST}, 32'd0);
      check({tag, "_hprot"}, {28'd0, HPROT}, 32'd3);
      check({tag, "_hwdata"}, HWDATA, 32'd0);
   endtask

   initial begin
      HRESETn = 1'b1;
      READ    = 1'b1;
      HRDATA  = 16'h0000;
      HREADY  = 1'b1;
      HRESP   = 2'b00;

      // Reset held with READ asserted: nothing may start.
      for (int i = 0; i < 3; i++) begin
         step();
         check_bus("rst", 2'b00, 32'h0, 1'b0, 1'b0);
      end
      check("rst_dataout", {16'd0, DATAOUT}, 32'h0);
      check("rst_resp", {30'd0, RESP_err}, 32'h0);
      check_consts("rst");

      // Zero-wait OKAY read at 0x0.
      HRESETn = 1'b0;
      HRDATA  = 16'h1234;
      step();
      check_bus("rd0_addr", 2'b10, 32'h0, 1'b1, 1'b0);
      check("rd0_state_addr", {30'd0, fsm_state}, 32'd1);
      READ = 1'b0;
      step();
      check_bus("rd0_data", 2'b00, 32'h0, 1'b1, 1'b0);
      check("rd0_state_data", {30'd0, fsm_state}, 32'd2);
      step();
      check_bus("rd0_done", 2'b00, 32'h2, 1'b0, 1'b1);
      check("rd0_dataout", {16'd0, DATAOUT}, 32'h1234);
      check("rd0_resp", {30'd0, RESP_err}, 32'h0);
      step();
      check_bus("rd0_after", 2'b00, 32'h2, 1'b0, 1'b0);

      // Read at 0x2 with four data-phase wait states.
      READ = 1'b1;
      step();
      check_bus("rd1_addr", 2'b10, 32'h2, 1'b1, 1'b0);
      READ = 1'b0;
      step();
      check_bus("rd1_data", 2'b00, 32'h2, 1'b1, 1'b0);
      HREADY = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         check_bus("rd1_wait", 2'b00, 32'h2, 1'b1, 1'b0);
      end
      HREADY = 1'b1;
      HRDATA = 16'hABCD;
      step();
      check_bus("rd1_done", 2'b00, 32'h4, 1'b0, 1'b1);
      check("rd1_dataout", {16'd0, DATAOUT}, 32'hABCD);
      step();
      check_bus("rd1_after", 2'b00, 32'h4, 1'b0, 1'b0);

      // Address-phase stall, then ERROR completion at 0x4.
      READ   = 1'b1;
      HREADY = 1'b0;
      step();
      check_bus("err_addr", 2'b10, 32'h4, 1'b1, 1'b0);
      READ = 1'b0;
      step();
      check_bus("err_stall", 2'b10, 32'h4, 1'b1, 1'b0);
      HREADY = 1'b1;
      step();
      check_bus("err_data", 2'b00, 32'h4, 1'b1, 1'b0);
      HRESP  = 2'b01;
      HRDATA = 16'h5555;
      step();
      check_bus("err_done", 2'b00, 32'h4, 1'b0, 1'b0);
      check("err_resp", {30'd0, RESP_err}, 32'h1);
      check("err_dataout", {16'd0, DATAOUT}, 32'hABCD);

      // Retry at the same address; READ held high from here on.
      HRESP = 2'b00;
      READ  = 1'b1;
      step();
      check_bus("retry_addr", 2'b10, 32'h4, 1'b1, 1'b0);
      check("retry_resp_hold", {30'd0, RESP_err}, 32'h1);
      step();
      check_bus("retry_data", 2'b00, 32'h4, 1'b1, 1'b0);
      HRDATA = 16'h4444;
      step();
      check_bus("retry_done", 2'b00, 32'h0, 1'b0, 1'b1);
      check("retry_dataout", {16'd0, DATAOUT}, 32'h4444);
      check("retry_resp", {30'd0, RESP_err}, 32'h0);

      // Wrapped to 0x0; back-to-back restart one cycle after IDLE.
      step();
      check_bus("wrap_addr", 2'b10, 32'h0, 1'b1, 1'b0);
      step();
      HRDATA = 16'h7777;
      step();
      check_bus("wrap_done", 2'b00, 32'h2, 1'b0, 1'b1);
      check("wrap_dataout", {16'd0, DATAOUT}, 32'h7777);
      step();
      check_bus("b2b_addr", 2'b10, 32'h2, 1'b1, 1'b0);
      READ = 1'b0;
      step();
      check_bus("b2b_data", 2'b00, 32'h2, 1'b1, 1'b0);

      // Reset during the data phase abandons the transfer.
      HRESETn = 1'b1;
      HRDATA  = 16'h9999;
      step();
      check_bus("midrst", 2'b00, 32'h0, 1'b0, 1'b0);
      check("midrst_dataout", {16'd0, DATAOUT}, 32'h0);
      check("midrst_state", {30'd0, fsm_state}, 32'd0);
      check_consts("midrst");
      HRESETn = 1'b0;
      step();
      check_bus("post_rst", 2'b00, 32'h0, 1'b0, 1'b0);

      // One more read confirms normal operation from ADDR_START.
      READ   = 1'b1;
      HRDATA = 16'h0F0F;
      step();
      check_bus("final_addr", 2'b10, 32'h0, 1'b1, 1'b0);
      READ = 1'b0;
      step();
      step();
      check_bus("final_done", 2'b00, 32'h2, 1'b0, 1'b1);
      check("final_dataout", {16'd0, DATAOUT}, 32'h0F0F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_bus.md
AHB_BUS -- requirements
Module: ahb_bus

Interface
REQ-001 Parameter ADDR_START, default 32'h0000_0000: first read address and wrap target.
REQ-002 Parameter ADDR_LAST, default 32'h0000_00FE: last read address before wrap.
REQ-003 Parameter ADDR_INCR, default 2: byte increment after each successful read.
REQ-004 Clocking: single clock HCLK; reset port HRESETn is synchronous and active-high (HRESETn=1 resets on the HCLK rising edge).
REQ-005 Ports (name  direction  width  meaning):
  HCLK  in  1  rising-edge clock
  HRESETn  in  1  synchronous active-high reset
  READ  in  1  level request for one halfword read
  DATAOUT  out  16  last successfully read data
  HADDR  out  32  AHB address
  HTRANS  out  2  AHB transfer type (00 IDLE, 10 NONSEQ)
  HWRITE  out  1  always 0 (read-only master)
  HSIZE  out  3  constant 3'b001 (halfword)
  HBURST  out  3  constant 3'b000 (SINGLE)
  HPROT  out  4  constant 4'b0011 (data, privileged)
  HWDATA  out  32  constant 0
  HRDATA  in  16  AHB read data
  HREADY  in  1  slave ready / transfer complete
  HRESP  in  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
  RESP_err  out  2  HRESP captured at last data-phase completion
  AHB_BUSY  out  1  transfer in progress
  VALID  out  1  one-cycle strobe: DATAOUT updated
REQ-006 All outputs SHALL be registered.

Function
REQ-007 FSM states IDLE, ADDR, DATA; one transfer in flight at a time.
REQ-008 IDLE: READ=1 at a rising edge -> ADDR; HTRANS=10, HADDR=addr_reg, AHB_BUSY=1 after that edge.
REQ-009 ADDR: HREADY=1 at an edge -> DATA and HTRANS=00; HREADY=0 -> stay in ADDR, holding HADDR/HTRANS stable.
REQ-010 DATA: HREADY=0 -> wait; HREADY=1 at an edge -> completion, return to IDLE, AHB_BUSY=0.
REQ-011 Completion with HRESP=00: DATAOUT<=HRDATA, VALID=1 for exactly one cycle, RESP_err<=00, addr_reg advances.
REQ-012 Completion with HRESP!=00: DATAOUT unchanged, VALID stays 0, RESP_err<=HRESP, addr_reg not advanced (next request retries the same address).
REQ-013 RESP_err holds its value until the next completion.
REQ-014 Address advance: addr_reg==ADDR_LAST -> ADDR_START; else addr_reg+ADDR_INCR (32-bit unsigned, no carry-out).
REQ-015 Minimum latency: READ sampled at edge k -> HTRANS=NONSEQ after k, DATA after k+1, VALID=1 after k+2 (zero slave wait states).
REQ-016 Back-to-back: READ held high -> new ADDR phase one cycle after returning to IDLE; minimum 3 cycles per read.
REQ-017 READ deasserted after acceptance SHALL NOT abort the transfer; READ is ignored outside IDLE.
REQ-018 HWRITE, HSIZE, HBURST, HPROT and HWDATA SHALL hold their constant values in every state, including during reset.

Reset
REQ-019 HRESETn=1 at an edge: state=IDLE, addr_reg=HADDR=ADDR_START, HTRANS=00, DATAOUT=0, RESP_err=00, AHB_BUSY=0, VALID=0.
REQ-020 Reset takes priority over all other inputs; reset mid-transfer abandons it with no VALID strobe and no address advance.
REQ-021 While HRESETn=1 no transfer starts, regardless of READ.

Verification
REQ-022 Reset with READ=1 -> HTRANS=00, HADDR=0, VALID=0, AHB_BUSY=0 throughout reset.
REQ-023 Release reset, READ=1, HREADY=1, HRDATA=16'h1234, HRESP=00 -> NONSEQ at 0x0, VALID pulses two cycles after acceptance, DATAOUT=16'h1234, next HADDR=0x2.
REQ-024 HREADY=0 for 4 cycles in the data phase, then HREADY=1 with HRDATA=16'hABCD -> AHB_BUSY high throughout wait, single VALID pulse, DATAOUT=16'hABCD.
REQ-025 Completion with HRESP=01 -> RESP_err=01, VALID=0, DATAOUT unchanged, retry issued at the same HADDR.
REQ-026 ADDR_LAST=32'h4, READ held high -> HADDR sequence 0x0, 0x2, 0x4, 0x0.
REQ-027 HRESETn=1 asserted during the DATA phase -> IDLE next cycle, no VALID pulse, HADDR=ADDR_START.
